fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  IF stage. Generates the fetch PC, issues requests to instruction memory and buffers
//  returned words with their PCs in a small prefetch queue. Feeds PC_in/inst_in of the
//  IF/ID pipeline register. Honours the hazard stall, applies taken-branch/jump redirects
//  and squashes wrong-path fetches by emitting NOP bubbles.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch address after reset
//  FIFO_DEPTH 4              prefetch entries; power of 2, >=2
//  NOP_INST   32'h0000_0013  bubble word (addi x0,x0,0)
// PORTS
//  clk          in  1   clock, rising edge
//  rst          in  1   reset, asynchronous, active-low
//  imem_req     out 1   fetch request valid
//  imem_addr    out 32  fetch address, word aligned
//  imem_gnt     in  1   request accepted this cycle (imem_req & imem_gnt = issue)
//  imem_rvalid  in  1   read data valid; responses in issue order, >=1 cycle after issue
//  imem_rdata   in  32  instruction word
//  stall        in  1   IF/ID hold (load-use hazard); head entry not consumed
//  redirect     in  1   control transfer resolved; flush and refetch
//  redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
//  halt         in  1   sys/ecall retired; stop issuing new fetches
//  PC_out       out 32  PC of presented instruction (to IF/ID PC_in)
//  inst_out     out 32  presented instruction or NOP_INST (to IF/ID inst_in)
//  inst_valid   out 1   inst_out is a real fetched word
// BEHAVIOUR
//  Reset (rst=0): fetch_pc=RESET_PC, queue empty, outstanding=0, drop=0, state=RUN;
//   imem_req=0, imem_addr=RESET_PC, PC_out=RESET_PC, inst_out=NOP_INST, inst_valid=0.
//   Reset mid-operation discards queue, outstanding and drop counts immediately.
//  FSM: RUN - issue allowed; HALT - no issue, queue keeps draining to IF/ID.
//   RUN->HALT on halt=1; HALT->RUN only on redirect=1. halt ignored if redirect same cycle.
//  Issue: imem_req=1 iff state=RUN, !redirect, and count+outstanding < FIFO_DEPTH
//   (credit rule: queue can never overflow). imem_addr=fetch_pc. On issue
//   fetch_pc <= fetch_pc+4 (mod 2^32, wraps FFFF_FFFC->0000_0000), outstanding++.
//  Response: imem_rvalid with drop>0 -> discarded, drop--. Otherwise {pc_tag,rdata}
//   pushed; pc_tag from an in-order tag FIFO of issued addresses. outstanding-- either way.
//  Presentation (combinational from queue head): queue non-empty -> PC_out=head pc,
//   inst_out=head inst, inst_valid=1; empty -> inst_out=NOP_INST, inst_valid=0,
//   PC_out=fetch_pc. Head popped on clock edge when non-empty & !stall & !redirect.
//  Latency: issue in cycle N, rvalid in N+1 -> presented in N+2. Back-to-back issue
//   with 1-cycle memory sustains 1 instr/cycle.
//  Simultaneous push+pop legal, count unchanged. Issue and response same cycle:
//   outstanding unchanged.
//  Redirect (priority over stall, halt, issue): same cycle inst_out=NOP_INST,
//   inst_valid=0; at edge queue and tag FIFO cleared, fetch_pc<=redirect_pc&~3,
//   drop <= outstanding minus any non-dropped response arriving this cycle (that
//   response is also discarded), outstanding <= drop value, state<=RUN. No issue in
//   redirect cycle; issue resumes next cycle as soon as credit allows.
//  Redirect while drop>0: drop accumulates; all stale words discarded before new path.
//  Stall with empty queue: no effect on fetch; bubble keeps being presented.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_stall_cnt[31:0] (cycles with stall=1
//   and queue non-empty), perf_flush_cnt[31:0] (redirect cycles), perf_drop_cnt[31:0]
//   (discarded responses); reset 0, saturate at FFFF_FFFF. Not defined: ports and
//   counters absent; all other behaviour identical.
// TESTING
//  Reset release, 1-cycle mem, no stall -> addrs 0,4,8,..; PC_out 0 with inst_valid=1
//   2 cycles after first issue; one instr per cycle thereafter.
//  stall=1 for 3 cycles at PC 0x10 -> PC_out/inst_out held at 0x10; imem_req drops once
//   count+outstanding=4; resumes 0x14 after release, no word lost or duplicated.
//  redirect=1, redirect_pc=0x203 with 2 outstanding -> NOP bubble, next issue addr 0x200,
//   2 stale responses dropped, first valid PC_out=0x200.
//  RESET_PC=FFFF_FFF8 -> issue FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
//  halt=1 with 3 queued -> no further imem_req, 3 words then NOP/inst_valid=0;
//   redirect to 0x40 -> fetch restarts at 0x40.
//  rst=0 mid-burst with responses pending -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch (IF) stage. Generates the fetch PC, issues
//               requests to instruction memory, and buffers returned words
//               with their PCs in a small prefetch queue that feeds the IF/ID
//               pipeline register. Honours the hazard stall, applies
//               branch/jump redirects, and squashes wrong-path fetches.
//
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous reset, active low
//               imem_req     - fetch request valid
//               imem_addr    - fetch address (word aligned)
//               imem_gnt     - request accepted (req & gnt = issue)
//               imem_rvalid  - read data valid, responses in issue order
//               imem_rdata   - returned instruction word
//               stall        - IF/ID hold; head entry is not consumed
//               redirect     - control transfer; flush and refetch
//               redirect_pc  - new fetch address (bits [1:0] ignored)
//               halt         - stop issuing new fetches
//               PC_out       - PC of presented instruction
//               inst_out     - presented instruction or NOP_INST bubble
//               inst_valid   - inst_out is a real fetched word
//               perf_*_cnt   - optional saturating event counters
//
// Options     : FETCH_PERF_CNT_EN - when defined, adds perf_stall_cnt,
//               perf_flush_cnt and perf_drop_cnt outputs.
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] PC_out,
    output logic [31:0] inst_out,
    output logic        inst_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]    state_q,       state_d;
    logic [31:0]   fetch_pc_q,    fetch_pc_d;
    logic [PW-1:0] q_rd_ptr_q,    q_rd_ptr_d;
    logic [PW-1:0] q_wr_ptr_q,    q_wr_ptr_d;
    logic [CW-1:0] q_count_q,     q_count_d;
    logic [PW-1:0] t_rd_ptr_q,    t_rd_ptr_d;
    logic [PW-1:0] t_wr_ptr_q,    t_wr_ptr_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q,        drop_d;

    // Prefetch queue payload and in-order tag FIFO of issued addresses
    logic [31:0] q_pc_q   [FIFO_DEPTH];
    logic [31:0] q_inst_q [FIFO_DEPTH];
    logic [31:0] tag_q    [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic [CW:0] w_occupancy;
    logic        w_credit_ok;
    logic        w_issue;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_drop_rsp;

    // Queued words plus in-flight requests must never exceed the queue
    // depth, so every response is guaranteed a slot.
    assign w_occupancy = {1'b0, q_count_q} + {1'b0, outstanding_q};
    assign w_credit_ok = (w_occupancy < (CW+1)'(FIFO_DEPTH));

    // rst gates the request so the bus sees no request during reset.
    assign imem_req   = rst && (state_q == ST_RUN) && !redirect && w_credit_ok;
    assign imem_addr  = fetch_pc_q;
    assign w_issue    = imem_req && imem_gnt;

    assign w_empty    = (q_count_q == '0);
    assign w_drop_rsp = imem_rvalid && (drop_q != '0);
    // A response landing in a redirect cycle belongs to the old path.
    assign w_push     = imem_rvalid && (drop_q == '0) && !redirect;
    assign w_pop      = !w_empty && !stall && !redirect;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        q_rd_ptr_d    = q_rd_ptr_q;
        q_wr_ptr_d    = q_wr_ptr_q;
        q_count_d     = q_count_q;
        t_rd_ptr_d    = t_rd_ptr_q;
        t_wr_ptr_d    = t_wr_ptr_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;

        if (redirect) begin
            state_d    = ST_RUN;
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            q_rd_ptr_d = '0;
            q_wr_ptr_d = '0;
            q_count_d  = '0;
            t_rd_ptr_d = '0;
            t_wr_ptr_d = '0;
            // Everything still in flight is now stale; any response this
            // cycle retires one of them. Stale words accumulate across
            // back-to-back redirects because outstanding already counts
            // earlier to-be-dropped requests.
            drop_d        = outstanding_q - {{(CW-1){1'b0}}, imem_rvalid};
            outstanding_d = drop_d;
        end else begin
            if (halt) begin
                state_d = ST_HALT;
            end
            if (w_issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                t_wr_ptr_d = t_wr_ptr_q + 1'b1;
            end
            outstanding_d = outstanding_q
                          + {{(CW-1){1'b0}}, w_issue}
                          - {{(CW-1){1'b0}}, imem_rvalid};
            drop_d = drop_q - {{(CW-1){1'b0}}, w_drop_rsp};
            if (w_push) begin
                q_wr_ptr_d = q_wr_ptr_q + 1'b1;
                t_rd_ptr_d = t_rd_ptr_q + 1'b1;
            end
            if (w_pop) begin
                q_rd_ptr_d = q_rd_ptr_q + 1'b1;
            end
            q_count_d = q_count_q
                      + {{(CW-1){1'b0}}, w_push}
                      - {{(CW-1){1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            q_rd_ptr_q    <= '0;
            q_wr_ptr_q    <= '0;
            q_count_q     <= '0;
            t_rd_ptr_q    <= '0;
            t_wr_ptr_q    <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            q_rd_ptr_q    <= q_rd_ptr_d;
            q_wr_ptr_q    <= q_wr_ptr_d;
            q_count_q     <= q_count_d;
            t_rd_ptr_q    <= t_rd_ptr_d;
            t_wr_ptr_q    <= t_wr_ptr_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Payload storage needs no reset: validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            tag_q[t_wr_ptr_q] <= fetch_pc_q;
        end
        if (w_push) begin
            q_pc_q[q_wr_ptr_q]   <= tag_q[t_rd_ptr_q];
            q_inst_q[q_wr_ptr_q] <= imem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Presentation to IF/ID
    // ------------------------------------------------------------------
    assign PC_out     = w_empty ? fetch_pc_q : q_pc_q[q_rd_ptr_q];
    assign inst_valid = !w_empty && !redirect;
    assign inst_out   = inst_valid ? q_inst_q[q_rd_ptr_q] : NOP_INST;

`ifdef FETCH_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [31:0] perf_stall_q, perf_flush_q, perf_drop_q;
    logic        w_stall_evt;
    logic        w_drop_evt;

    assign w_stall_evt = stall && !w_empty;
    assign w_drop_evt  = imem_rvalid && ((drop_q != '0) || redirect);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            if (w_stall_evt && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (redirect && (perf_flush_q != 32'hFFFF_FFFF)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
            if (w_drop_evt && (perf_drop_q != 32'hFFFF_FFFF)) begin
                perf_drop_q <= perf_drop_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_drop_cnt  = perf_drop_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. A behavioural
//               instruction memory with selectable latency returns
//               addr ^ 32'h5A5A_0000 as the instruction word. A second
//               instance with RESET_PC = FFFF_FFF8 exercises address wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_gnt;
    logic        stall;
    logic        redirect;
    logic        halt;
    logic [31:0] redirect_pc;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    wire         imem_req;
    wire  [31:0] imem_addr;
    wire  [31:0] PC_out;
    wire  [31:0] inst_out;
    wire         inst_valid;

    wire         w2_req;
    wire  [31:0] w2_addr;
    wire  [31:0] w2_pc;
    wire  [31:0] w2_inst;
    wire         w2_valid;

`ifdef FETCH_PERF_CNT_EN
    wire [31:0] p_stall, p_flush, p_drop, p2_stall, p2_flush, p2_drop;
`endif

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .PC_out(PC_out), .inst_out(inst_out),
        .inst_valid(inst_valid)
`ifdef FETCH_PERF_CNT_EN
        , .perf_stall_cnt(p_stall), .perf_flush_cnt(p_flush), .perf_drop_cnt(p_drop)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w2_req), .imem_addr(w2_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(1'b0), .imem_rdata(32'h0),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .halt(1'b0), .PC_out(w2_pc), .inst_out(w2_inst),
        .inst_valid(w2_valid)
`ifdef FETCH_PERF_CNT_EN
        , .perf_stall_cnt(p2_stall), .perf_flush_cnt(p2_flush), .perf_drop_cnt(p2_drop)
`endif
    );

    // ------------------------------------------------------------------
    // Instruction memory: in-order responses after 'lat' cycles (1..4)
    // ------------------------------------------------------------------
    int          lat = 1;
    logic        pv [4];
    logic [31:0] pa [4];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= 32'h0;
            end
        end else begin
            for (int i = 3; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
            pv[0] <= imem_req && imem_gnt;
            pa[0] <= imem_addr;
        end
    end

    always_comb begin
        imem_rvalid = pv[lat-1];
        imem_rdata  = pa[lat-1] ^ 32'h5A5A_0000;
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next negedge (inputs are driven here, away from posedge)
    task automatic cyc();
        @(negedge clk);
    endtask

    // Hold reset two cycles with the given memory latency, then release.
    // Returns at the negedge of cycle C0 (first cycle out of reset).
    task automatic do_reset(input int l);
        cyc();
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
        redirect_pc = 32'h0; lat = l;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; imem_gnt = 1'b1; stall = 1'b0; redirect = 1'b0;
        halt = 1'b0; redirect_pc = 32'h0; lat = 1;

        // ---------------- Reset values ----------------
        cyc(); cyc(); #1;
        check("rst_req",   imem_req,   0);
        check("rst_addr",  imem_addr,  32'h0);
        check("rst_pc",    PC_out,     32'h0);
        check("rst_inst",  inst_out,   NOP);
        check("rst_valid", inst_valid, 0);
        check("rst_wrap_addr", w2_addr, 32'hFFFF_FFF8);

        // ---------------- Streaming, 1-cycle memory ----------------
        rst = 1'b1; #1;                                // C0
        check("c0_req",  imem_req,  1);
        check("c0_addr", imem_addr, 32'h0);
        check("wrap0",   w2_addr,   32'hFFFF_FFF8);
        cyc(); #1;                                     // C1
        check("c1_addr",  imem_addr,  32'h4);
        check("c1_valid", inst_valid, 0);
        check("wrap1",    w2_addr,    32'hFFFF_FFFC);
        cyc(); #1;                                     // C2
        check("c2_valid", inst_valid, 1);
        check("c2_pc",    PC_out,     32'h0);
        check("c2_inst",  inst_out,   word(32'h0));
        check("c2_addr",  imem_addr,  32'h8);
        check("wrap2",    w2_addr,    32'h0000_0000);
        for (int k = 3; k <= 5; k++) begin             // C3..C5
            cyc(); #1;
            check("stream_pc",    PC_out,     32'(4 * (k - 2)));
            check("stream_valid", inst_valid, 1);
        end

        // ---------------- Stall at PC 0x10 for 3 cycles ----------------
        cyc(); stall = 1'b1; #1;                       // C6
        check("st6_pc", PC_out, 32'h10);
        cyc(); #1;                                     // C7
        check("st7_pc",   PC_out,    32'h10);
        check("st7_req",  imem_req,  1);
        check("st7_addr", imem_addr, 32'h1C);
        cyc(); #1;                                     // C8
        check("st8_pc",   PC_out,   32'h10);
        check("st8_inst", inst_out, word(32'h10));
        check("st8_req",  imem_req, 0);
        cyc(); stall = 1'b0; #1;                       // C9
        check("st9_pc",  PC_out,   32'h10);
        check("st9_req", imem_req, 0);
        cyc(); #1;                                     // C10
        check("st10_pc",   PC_out,    32'h14);
        check("st10_addr", imem_addr, 32'h20);
        for (int k = 11; k <= 14; k++) begin           // C11..C14
            cyc(); #1;
            check("post_stall_pc",   PC_out,     32'(32'h18 + 4 * (k - 11)));
            check("post_stall_inst", inst_out,   word(32'(32'h18 + 4 * (k - 11))));
            check("post_stall_vld",  inst_valid, 1);
        end

        // ---------------- Redirect with stale responses (3-cycle mem) ----
        do_reset(3); #1;                               // C0
        check("rd_c0_addr", imem_addr, 32'h0);
        cyc(); cyc(); cyc();                           // C3
        cyc(); #1;                                     // C4: head = 0
        check("rd_pre_valid", inst_valid, 1);
        check("rd_pre_pc",    PC_out,     32'h0);
        redirect = 1'b1; redirect_pc = 32'h203; #1;
        check("rd_bubble_valid", inst_valid, 0);
        check("rd_bubble_inst",  inst_out,   NOP);
        check("rd_bubble_req",   imem_req,   0);
        cyc(); redirect = 1'b0; #1;                    // C5
        check("rd_new_req",  imem_req,   1);
        check("rd_new_addr", imem_addr,  32'h200);
        check("rd_c5_valid", inst_valid, 0);
        for (int k = 6; k <= 8; k++) begin             // C6..C8: stale dropped
            cyc(); #1;
            check("rd_stale_valid", inst_valid, 0);
        end
        cyc(); #1;                                     // C9
        check("rd_first_valid", inst_valid, 1);
        check("rd_first_pc",    PC_out,     32'h200);
        check("rd_first_inst",  inst_out,   word(32'h200));
        cyc(); #1;                                     // C10
        check("rd_second_pc", PC_out, 32'h204);

        // ---------------- Halt with 3 queued, then redirect ----------------
        do_reset(1); stall = 1'b1; #1;                 // C0
        check("h_c0_addr", imem_addr, 32'h0);
        cyc();                                         // C1
        cyc(); halt = 1'b1; #1;                        // C2
        check("h_c2_req",  imem_req,  1);
        check("h_c2_addr", imem_addr, 32'h8);
        cyc(); halt = 1'b0; #1;                        // C3
        check("h_c3_req", imem_req, 0);
        check("h_c3_pc",  PC_out,   32'h0);
        cyc(); stall = 1'b0; #1;                       // C4
        check("h_c4_req", imem_req, 0);
        check("h_c4_pc",  PC_out,   32'h0);
        cyc(); #1;                                     // C5
        check("h_c5_pc", PC_out, 32'h4);
        cyc(); #1;                                     // C6
        check("h_c6_pc",  PC_out,   32'h8);
        check("h_c6_req", imem_req, 0);
        cyc(); #1;                                     // C7: drained
        check("h_c7_valid", inst_valid, 0);
        check("h_c7_inst",  inst_out,   NOP);
        check("h_c7_pc",    PC_out,     32'hC);
        check("h_c7_req",   imem_req,   0);
        cyc(); redirect = 1'b1; redirect_pc = 32'h40; #1;   // C8
        check("h_c8_req", imem_req, 0);
        cyc(); redirect = 1'b0; #1;                    // C9
        check("h_restart_req",  imem_req,  1);
        check("h_restart_addr", imem_addr, 32'h40);
        cyc(); #1;                                     // C10
        check("h_c10_addr", imem_addr, 32'h44);
        cyc(); #1;                                     // C11
        check("h_c11_pc",    PC_out,     32'h40);
        check("h_c11_valid", inst_valid, 1);

        // ---------------- Reset mid-burst ----------------
        do_reset(3);                                   // C0
        cyc(); cyc(); cyc(); cyc(); #1;                // C4: head 0 valid
        check("mr_pre_valid", inst_valid, 1);
        rst = 1'b0; #1;
        check("mr_req",   imem_req,   0);
        check("mr_addr",  imem_addr,  32'h0);
        check("mr_pc",    PC_out,     32'h0);
        check("mr_inst",  inst_out,   NOP);
        check("mr_valid", inst_valid, 0);
        cyc(); rst = 1'b1; #1;                         // new C0
        check("mr_c0_req",  imem_req,  1);
        check("mr_c0_addr", imem_addr, 32'h0);
        cyc(); cyc(); #1;                              // C2
        check("mr_c2_valid", inst_valid, 0);
        cyc(); cyc(); #1;                              // C4
        check("mr_c4_pc",    PC_out,     32'h0);
        check("mr_c4_valid", inst_valid, 1);
        check("mr_c4_inst",  inst_out,   word(32'h0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
